// File: rtl/uart_cmd_rx_pkg.sv
// Shared types and command codes for the UART command receiver.
// Imported by the interface, the byte receiver and the framer.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_INSTR = 8'h00;
    localparam logic [7:0] CMD_RUN   = 8'h02;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT_HIGH
    } rx_state_e;

    typedef enum logic [1:0] {
        F_IDLE,
        F_INSTR,
        F_DATA
    } fr_state_e;

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Signal bundle between the board/CPU side and the UART command receiver.
// Every strobe is a one-cycle valid with no ready: the consumer must take word_out on the pulse cycle.
interface uart_cmd_rx_if;
    import uart_cmd_pkg::*;

    logic        rx;
    logic        data_req;
    logic [31:0] word_out;
    logic        instr_valid;
    logic        data_valid;
    logic        run_pulse;
    logic        frame_err;
    logic        cmd_err;
    logic        busy;
    rx_state_e   dbg_rx_state;
    fr_state_e   dbg_fr_state;

    modport slave (
        input  rx, data_req,
        output word_out, instr_valid, data_valid, run_pulse, frame_err, cmd_err, busy,
        output dbg_rx_state, dbg_fr_state
    );

    modport master (
        output rx, data_req,
        input  word_out, instr_valid, data_valid, run_pulse, frame_err, cmd_err, busy,
        input  dbg_rx_state, dbg_fr_state
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with a 2-flop input synchroniser.
// byte_valid and frame_err are registered one-cycle pulses; byte_data holds the last byte shifted in.
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output rx_state_e  state_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) state_d = R_START;
            end
            R_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        state_d = R_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = R_WAIT_HIGH;
                    end
                end
            end
            R_WAIT_HIGH: begin
                // A held-low line (break) must go high before a new start bit counts.
                cnt_d = '0;
                if (rx_s) state_d = R_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;
    assign state_o    = state_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART loader front end: frames received bytes into instruction words, data words and run requests.
// All strobes leave from registers and at most one of them is high in any cycle.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic          clk,
    input logic          reset,
    uart_cmd_rx_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rx_ferr;
    rx_state_e  rx_state;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk       (clk),
        .reset     (reset),
        .rx        (bus.rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (rx_ferr),
        .state_o   (rx_state)
    );

    fr_state_e     fr_q, fr_d;
    logic [1:0]    k_q, k_d;
    logic [23:0]   shift_q, shift_d;
    logic [31:0]   word_q, word_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          iv_q, iv_d;
    logic          dv_q, dv_d;
    logic          run_q, run_d;
    logic          ferr_q, ferr_d;
    logic          cerr_q, cerr_d;

    always_comb begin
        fr_d    = fr_q;
        k_d     = k_q;
        shift_d = shift_q;
        word_d  = word_q;
        tmo_d   = tmo_q + 1'b1;
        iv_d    = 1'b0;
        dv_d    = 1'b0;
        run_d   = 1'b0;
        ferr_d  = rx_ferr;
        cerr_d  = 1'b0;
        case (fr_q)
            F_IDLE: begin
                tmo_d = '0;
                if (byte_valid) begin
                    // A pending CPU data load claims the byte before command decode.
                    if (bus.data_req) begin
                        shift_d[7:0] = byte_data;
                        k_d          = 2'd1;
                        fr_d         = F_DATA;
                    end else if (byte_data == CMD_INSTR) begin
                        k_d  = 2'd0;
                        fr_d = F_INSTR;
                    end else if (byte_data == CMD_RUN) begin
                        run_d = 1'b1;
                    end else begin
                        cerr_d = 1'b1;
                    end
                end
            end
            F_INSTR, F_DATA: begin
                if (byte_valid) begin
                    tmo_d = '0;
                    k_d   = k_q + 2'd1;
                    case (k_q)
                        2'd0:    shift_d[7:0]   = byte_data;
                        2'd1:    shift_d[15:8]  = byte_data;
                        2'd2:    shift_d[23:16] = byte_data;
                        default: begin
                            word_d = {byte_data, shift_q};
                            iv_d   = (fr_q == F_INSTR);
                            dv_d   = (fr_q == F_DATA);
                            fr_d   = F_IDLE;
                        end
                    endcase
                end else if (rx_ferr) begin
                    fr_d = F_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    cerr_d = 1'b1;
                    fr_d   = F_IDLE;
                end
            end
            default: begin
                fr_d = F_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fr_q    <= F_IDLE;
            k_q     <= '0;
            shift_q <= '0;
            word_q  <= '0;
            tmo_q   <= '0;
            iv_q    <= 1'b0;
            dv_q    <= 1'b0;
            run_q   <= 1'b0;
            ferr_q  <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            fr_q    <= fr_d;
            k_q     <= k_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            tmo_q   <= tmo_d;
            iv_q    <= iv_d;
            dv_q    <= dv_d;
            run_q   <= run_d;
            ferr_q  <= ferr_d;
            cerr_q  <= cerr_d;
        end
    end

    assign bus.word_out     = word_q;
    assign bus.instr_valid  = iv_q;
    assign bus.data_valid   = dv_q;
    assign bus.run_pulse    = run_q;
    assign bus.frame_err    = ferr_q;
    assign bus.cmd_err      = cerr_q;
    assign bus.busy         = (fr_q != F_IDLE);
    assign bus.dbg_rx_state = rx_state;
    assign bus.dbg_fr_state = fr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed plus randomized bench for uart_cmd_rx with a scaled bit period and timeout.
// Expected words come from the base-256 value of the bytes sent; strobes are counted by a monitor.
module tb_uart_cmd_rx;
    import uart_cmd_pkg::*;

    localparam int CPB = 16;
    localparam int TMO = 3000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_cmd_rx_if bus();

    uart_cmd_rx #(
        .CLKS_PER_BIT  (CPB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;
    int n_instr = 0, n_data = 0, n_run = 0, n_ferr = 0, n_cerr = 0, n_multi = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Strobe monitor and word scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            logic [32:0] e;
            int s;
            s = int'(bus.instr_valid) + int'(bus.data_valid) + int'(bus.run_pulse)
              + int'(bus.frame_err) + int'(bus.cmd_err);
            if (s > 1) n_multi++;
            if (bus.instr_valid) n_instr++;
            if (bus.data_valid) n_data++;
            if (bus.run_pulse) n_run++;
            if (bus.frame_err) n_ferr++;
            if (bus.cmd_err) n_cerr++;
            if (bus.instr_valid || bus.data_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_word", bus.word_out, e[31:0]);
                    check("sb_kind", {31'b0, bus.data_valid}, {31'b0, e[32]});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            idle(CPB);
        end
        bus.rx = stop;
        idle(CPB);
        bus.rx = 1'b1;
        if (!stop) idle(CPB);
    endtask

    // Sends one complete word frame; byte i is the i-th base-256 digit of w.
    task automatic do_frame(input logic [31:0] w, input logic is_data, input logic drop_req);
        int ni0, nd0;
        ni0 = n_instr;
        nd0 = n_data;
        bus.data_req = is_data;
        exp_q.push_back({is_data, w});
        if (!is_data) begin
            send_byte(CMD_INSTR, 1'b1);
            idle($urandom_range(0, 12));
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(8'((w / (32'd1 << (8 * i))) % 256), 1'b1);
            if (i == 0 && drop_req) bus.data_req = 1'b0;
            if (i == 1) check("busy_mid_frame", {31'b0, bus.busy}, 32'd1);
            idle($urandom_range(0, 12));
        end
        idle(20);
        bus.data_req = 1'b0;
        check("instr_pulses", 32'(n_instr - ni0), is_data ? 32'd0 : 32'd1);
        check("data_pulses", 32'(n_data - nd0), is_data ? 32'd1 : 32'd0);
        check("word_out", bus.word_out, w);
        check("busy_after", {31'b0, bus.busy}, 32'd0);
        last_word = w;
    endtask

    initial begin
        int c0, r0, f0, i0, t0;
        logic [7:0] b;
        reset        = 1'b1;
        bus.rx       = 1'b1;
        bus.data_req = 1'b0;
        last_word    = '0;
        idle(5);
        check("rst_word", bus.word_out, 32'd0);
        check("rst_strobes", {27'b0, bus.instr_valid, bus.data_valid, bus.run_pulse,
                              bus.frame_err, bus.cmd_err}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        reset = 1'b0;
        idle(5);

        // Instruction frame 00 13 01 50 00.
        do_frame(32'h00500113, 1'b0, 1'b0);

        // Run request.
        r0 = n_run; i0 = n_instr + n_data;
        send_byte(CMD_RUN, 1'b1);
        idle(20);
        check("run_pulses", 32'(n_run - r0), 32'd1);
        check("run_no_valid", 32'(n_instr + n_data - i0), 32'd0);
        check("run_word_hold", bus.word_out, last_word);

        // Data words, including a leading 00 and data_req dropped mid-frame.
        do_frame(32'd7, 1'b1, 1'b0);
        do_frame(32'hA5C3_1E00, 1'b1, 1'b0);
        do_frame({$urandom_range(0, 255), 24'h0} | 32'($urandom_range(0, 65535)), 1'b1, 1'b1);

        // Stop bit low in idle.
        f0 = n_ferr; c0 = n_cerr;
        send_byte(8'h55, 1'b0);
        idle(20);
        check("ferr_pulses", 32'(n_ferr - f0), 32'd1);
        check("ferr_no_cerr", 32'(n_cerr - c0), 32'd0);
        check("ferr_word_hold", bus.word_out, last_word);
        do_frame(32'h00800A6F, 1'b0, 1'b0);

        // Stop bit low inside a frame aborts it.
        f0 = n_ferr; c0 = n_cerr;
        send_byte(CMD_INSTR, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h99, 1'b0);
        idle(20);
        check("ferr_in_frame", 32'(n_ferr - f0), 32'd1);
        check("ferr_in_frame_cerr", 32'(n_cerr - c0), 32'd0);
        check("ferr_in_frame_busy", {31'b0, bus.busy}, 32'd0);

        // Inter-byte timeout.
        c0 = n_cerr; i0 = n_instr;
        send_byte(CMD_INSTR, 1'b1);
        send_byte(8'h93, 1'b1);
        send_byte(8'h01, 1'b1);
        check("tmo_busy_before", {31'b0, bus.busy}, 32'd1);
        idle(TMO + 50);
        check("tmo_cerr", 32'(n_cerr - c0), 32'd1);
        check("tmo_busy_after", {31'b0, bus.busy}, 32'd0);
        check("tmo_no_instr", 32'(n_instr - i0), 32'd0);
        check("tmo_word_hold", bus.word_out, last_word);
        do_frame($urandom(), 1'b0, 1'b0);

        // Unknown command byte.
        c0 = n_cerr;
        send_byte(8'h41, 1'b1);
        idle(20);
        check("bad_cmd_cerr", 32'(n_cerr - c0), 32'd1);

        // Short low glitch is a false start.
        t0 = n_instr + n_data + n_run + n_ferr + n_cerr;
        bus.rx = 1'b0;
        idle(5);
        bus.rx = 1'b1;
        idle(3 * CPB);
        check("glitch_quiet", 32'(n_instr + n_data + n_run + n_ferr + n_cerr - t0), 32'd0);

        // Reset in the middle of a frame.
        send_byte(CMD_INSTR, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(3);
        check("midrst_word", bus.word_out, 32'd0);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        last_word = '0;
        do_frame($urandom(), 1'b0, 1'b0);

        // Random mix of frames and single-byte commands.
        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(0, 3))
                0: do_frame($urandom(), 1'b0, 1'b0);
                1: do_frame($urandom(), 1'b1, 1'($urandom_range(0, 1)));
                2: begin
                    r0 = n_run;
                    send_byte(CMD_RUN, 1'b1);
                    idle(20);
                    check("rand_run", 32'(n_run - r0), 32'd1);
                    check("rand_run_word", bus.word_out, last_word);
                end
                default: begin
                    c0 = n_cerr;
                    b  = 8'($urandom_range(3, 255));
                    send_byte(b, 1'b1);
                    idle(20);
                    check("rand_bad_cmd", 32'(n_cerr - c0), 32'd1);
                    check("rand_bad_busy", {31'b0, bus.busy}, 32'd0);
                end
            endcase
            idle($urandom_range(0, 30));
        end

        check("strobes_exclusive", 32'(n_multi), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
